// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: depth/pointer sizing, level threshold compares and the
// per-cycle operation encoding used by the single- and dual-clock FIFOs.
package fifo_pkg;

   // What a FIFO actually does in one cycle once full/empty gating is applied
   typedef enum logic [1:0] {
      OP_IDLE  = 2'b00,
      OP_READ  = 2'b01,
      OP_WRITE = 2'b10,
      OP_BOTH  = 2'b11
   } fifo_op_e;

   function automatic int fifo_depth(input int addrWidth);
      return 2 ** addrWidth;
   endfunction

   // One extra MSB separates "full" from "empty" when the addresses match
   function automatic int ptr_width(input int addrWidth);
      return addrWidth + 1;
   endfunction

   function automatic logic level_at_least(input int level, input int threshold);
      return (level >= threshold);
   endfunction

   function automatic logic level_at_most(input int level, input int threshold);
      return (level <= threshold);
   endfunction

   // Thresholds must leave a non-empty gap and almost_full must be reachable
   function automatic logic params_legal(input int addrWidth, input int afLvl, input int aeLvl);
      return (aeLvl >= 0) && (aeLvl < afLvl) && (afLvl <= fifo_depth(addrWidth));
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_lvl: one write port, one read port that is either
// combinational (first-word-fall-through) or registered with a 1-cycle latency.
module sync_fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_DATA  = 4,
   parameter int FWFT       = 0
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_wrEn,
   input  logic [ADDR_DATA-1:0]  i_wrAddr,
   input  logic [DATA_WIDTH-1:0] i_wrData,
   input  logic                  i_rdEn,
   input  logic [ADDR_DATA-1:0]  i_rdAddr,
   output logic [DATA_WIDTH-1:0] o_rdData
);

   localparam int DEPTH = fifo_depth(ADDR_DATA);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Contents are never cleared; control logic guarantees stale words are not read
   always_ff @(posedge i_clk) begin
      if (i_wrEn) begin
         r_mem[i_wrAddr] <= i_wrData;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         logic w_unused;
         assign w_unused = &{1'b0, i_reset, i_rdEn};
         assign o_rdData = r_mem[i_rdAddr];
      end else begin : g_registered
         logic [DATA_WIDTH-1:0] r_rdData;
         // Capture the head only on an accepted read; hold the last word otherwise
         always_ff @(posedge i_clk) begin
            if (i_reset) begin
               r_rdData <= '0;
            end else if (i_rdEn) begin
               r_rdData <= r_mem[i_rdAddr];
            end
         end
         assign o_rdData = r_rdData;
      end
   endgenerate

endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with fill level, almost-full/almost-empty thresholds,
// selectable registered or first-word-fall-through read and error pulses.
module sync_fifo_lvl
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_DATA  = 4,
   parameter int AF_LVL     = 12,
   parameter int AE_LVL     = 2,
   parameter int FWFT       = 0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] WR_data,
   input  logic                  WR_inc,
   input  logic                  RD_inc,
   output logic [DATA_WIDTH-1:0] RD_data,
   output logic                  RD_valid,
   output logic                  WR_full,
   output logic                  RD_empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_DATA:0]    LEVEL,
   output logic                  WR_overflow,
   output logic                  RD_underflow
);

   localparam int DEPTH = fifo_depth(ADDR_DATA);
   localparam int PW    = ptr_width(ADDR_DATA);

   generate
      if (!params_legal(ADDR_DATA, AF_LVL, AE_LVL)) begin : g_badParams
         $error("sync_fifo_lvl: thresholds must satisfy 0 <= AE_LVL < AF_LVL <= DEPTH");
      end
   endgenerate

   logic [PW-1:0] r_wrPtr;
   logic [PW-1:0] r_rdPtr;
   logic [PW-1:0] r_level;
   logic          r_overflow;
   logic          r_underflow;
   logic          r_rdValid;
   logic          w_wrAccept;
   logic          w_rdAccept;
   fifo_op_e      w_op;

   // Flags come straight from the registered level so they never lag LEVEL
   assign WR_full      = (r_level == PW'(DEPTH));
   assign RD_empty     = (r_level == '0);
   assign almost_full  = level_at_least(int'(r_level), AF_LVL);
   assign almost_empty = level_at_most(int'(r_level), AE_LVL);
   assign LEVEL        = r_level;
   assign WR_overflow  = r_overflow;
   assign RD_underflow = r_underflow;
   assign RD_valid     = (FWFT != 0) ? !RD_empty : r_rdValid;

   // Full blocks writes and empty blocks reads, which also settles the
   // simultaneous cases at the boundaries
   assign w_wrAccept = WR_inc & ~WR_full;
   assign w_rdAccept = RD_inc & ~RD_empty;

   // Classify the cycle so the level update reads as a plain case
   always_comb begin
      w_op = OP_IDLE;
      case ({w_wrAccept, w_rdAccept})
         2'b01:   w_op = OP_READ;
         2'b10:   w_op = OP_WRITE;
         2'b11:   w_op = OP_BOTH;
         default: w_op = OP_IDLE;
      endcase
   end

   // Pointers, level and pulses; pointer wrap is plain modulo arithmetic
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         r_level     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_rdValid   <= 1'b0;
      end else begin
         if (w_wrAccept) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         if (w_rdAccept) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         case (w_op)
            OP_WRITE: r_level <= r_level + PW'(1);
            OP_READ:  r_level <= r_level - PW'(1);
            default:  r_level <= r_level;
         endcase
         r_overflow  <= WR_inc & WR_full;
         r_underflow <= RD_inc & RD_empty;
         r_rdValid   <= w_rdAccept;
      end
   end

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_DATA  (ADDR_DATA),
      .FWFT       (FWFT)
   ) u_mem (
      .i_clk    (CLK),
      .i_reset  (RST),
      .i_wrEn   (w_wrAccept),
      .i_wrAddr (r_wrPtr[ADDR_DATA-1:0]),
      .i_wrData (WR_data),
      .i_rdEn   (w_rdAccept),
      .i_rdAddr (r_rdPtr[ADDR_DATA-1:0]),
      .o_rdData (RD_data)
   );

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Bench for sync_fifo_lvl: a registered-read and a FWFT instance share the same
// stimulus and are compared against a queue-based model of the FIFO.
module tb_sync_fifo_lvl;

   localparam int DEPTH = 16;
   localparam int AFL   = 12;
   localparam int AEL   = 2;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] WR_data = '0;
   logic       WR_inc = 1'b0;
   logic       RD_inc = 1'b0;

   logic [7:0] RD_data0, RD_data1;
   logic       RD_valid0, RD_valid1, WR_full0, WR_full1, RD_empty0, RD_empty1;
   logic       almost_full0, almost_full1, almost_empty0, almost_empty1;
   logic [4:0] LEVEL0, LEVEL1;
   logic       WR_overflow0, WR_overflow1, RD_underflow0, RD_underflow1;

   int nTests = 0;
   int nFail  = 0;

   byte unsigned q[$];
   logic [7:0]   expData0 = '0;
   logic         expValid0 = 1'b0;
   logic         expOvf = 1'b0;
   logic         expUnf = 1'b0;

   always #5 CLK = ~CLK;

   sync_fifo_lvl #(.DATA_WIDTH(8), .ADDR_DATA(4), .AF_LVL(AFL), .AE_LVL(AEL), .FWFT(0)) dut0 (
      .CLK(CLK), .RST(RST), .WR_data(WR_data), .WR_inc(WR_inc), .RD_inc(RD_inc),
      .RD_data(RD_data0), .RD_valid(RD_valid0), .WR_full(WR_full0), .RD_empty(RD_empty0),
      .almost_full(almost_full0), .almost_empty(almost_empty0), .LEVEL(LEVEL0),
      .WR_overflow(WR_overflow0), .RD_underflow(RD_underflow0));

   sync_fifo_lvl #(.DATA_WIDTH(8), .ADDR_DATA(4), .AF_LVL(AFL), .AE_LVL(AEL), .FWFT(1)) dut1 (
      .CLK(CLK), .RST(RST), .WR_data(WR_data), .WR_inc(WR_inc), .RD_inc(RD_inc),
      .RD_data(RD_data1), .RD_valid(RD_valid1), .WR_full(WR_full1), .RD_empty(RD_empty1),
      .almost_full(almost_full1), .almost_empty(almost_empty1), .LEVEL(LEVEL1),
      .WR_overflow(WR_overflow1), .RD_underflow(RD_underflow1));

   // Drive one cycle, advance the model at the edge, leave outputs settled for sampling
   task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] d, input logic rst);
      bit full, empty;
      WR_inc  = wr;
      RD_inc  = rd;
      WR_data = d;
      RST     = rst;
      @(posedge CLK);
      if (rst) begin
         q.delete();
         expData0  = '0;
         expValid0 = 1'b0;
         expOvf    = 1'b0;
         expUnf    = 1'b0;
      end else begin
         full      = (q.size() == DEPTH);
         empty     = (q.size() == 0);
         expOvf    = wr && full;
         expUnf    = rd && empty;
         expValid0 = 1'b0;
         if (rd && !empty) begin
            expData0  = q.pop_front();
            expValid0 = 1'b1;
         end
         if (wr && !full) q.push_back(d);
      end
      #1;
      WR_inc = 1'b0;
      RD_inc = 1'b0;
      RST    = 1'b0;
   endtask

   task automatic test_reset();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      nTests++;
      if ({LEVEL0, RD_empty0, almost_empty0, WR_full0, almost_full0, RD_data0, RD_valid0, WR_overflow0, RD_underflow0}
          !== {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
         nFail++;
         $display("[TB] FAIL reset_state got lvl=%0d e=%b ae=%b f=%b af=%b d=%h v=%b o=%b u=%b want 0 1 1 0 0 00 0 0 0",
                  LEVEL0, RD_empty0, almost_empty0, WR_full0, almost_full0, RD_data0, RD_valid0, WR_overflow0, RD_underflow0);
      end
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
      nTests++;
      if (LEVEL0 !== 5'd5) begin
         nFail++;
         $display("[TB] FAIL pre_reset_level got %0d want 5", LEVEL0);
      end
      applyStimulus(1'b1, 1'b1, 8'h77, 1'b1);
      nTests++;
      if ({LEVEL0, LEVEL1, RD_empty0, RD_empty1, almost_empty0, almost_empty1, WR_overflow0, RD_underflow0, RD_valid0}
          !== {5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         nFail++;
         $display("[TB] FAIL midreset_state got lvl=%0d/%0d e=%b%b ae=%b%b o=%b u=%b v=%b want 0/0 11 11 0 0 0",
                  LEVEL0, LEVEL1, RD_empty0, RD_empty1, almost_empty0, almost_empty1, WR_overflow0, RD_underflow0, RD_valid0);
      end
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      nTests++;
      if ({RD_underflow0, LEVEL0} !== {1'b1, 5'd0}) begin
         nFail++;
         $display("[TB] FAIL post_reset_empty got unf=%b lvl=%0d want unf=1 lvl=0", RD_underflow0, LEVEL0);
      end
   endtask

   task automatic test_fill_drain();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 1'b0, 8'(i), 1'b0);
         nTests++;
         if ({LEVEL0, almost_full0, WR_full0, almost_empty0} !== {5'(i + 1), (i + 1) >= 12, i == 15, (i + 1) <= 2}) begin
            nFail++;
            $display("[TB] FAIL fill_flags write=%0d got lvl=%0d af=%b f=%b ae=%b", i + 1, LEVEL0, almost_full0, WR_full0, almost_empty0);
         end
      end
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
         nTests++;
         if ({RD_data0, RD_valid0, LEVEL0} !== {8'(i), 1'b1, 5'(15 - i)}) begin
            nFail++;
            $display("[TB] FAIL drain_data read=%0d got d=%h v=%b lvl=%0d want d=%h v=1 lvl=%0d",
                     i, RD_data0, RD_valid0, LEVEL0, 8'(i), 15 - i);
         end
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      nTests++;
      if ({RD_empty0, RD_valid0, RD_data0} !== {1'b1, 1'b0, 8'h0F}) begin
         nFail++;
         $display("[TB] FAIL drain_end got e=%b v=%b d=%h want e=1 v=0 d=0f", RD_empty0, RD_valid0, RD_data0);
      end
   endtask

   task automatic test_overflow_underflow();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
      applyStimulus(1'b1, 1'b0, 8'hAA, 1'b0);
      nTests++;
      if ({WR_overflow0, WR_overflow1, LEVEL0, WR_full0} !== {1'b1, 1'b1, 5'd16, 1'b1}) begin
         nFail++;
         $display("[TB] FAIL overflow_pulse got o=%b%b lvl=%0d f=%b want o=11 lvl=16 f=1", WR_overflow0, WR_overflow1, LEVEL0, WR_full0);
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      nTests++;
      if (WR_overflow0 !== 1'b0) begin
         nFail++;
         $display("[TB] FAIL overflow_single got o=%b want 0", WR_overflow0);
      end
      for (int i = 0; i < 16; i++) begin
         nTests++;
         if (RD_data1 !== 8'(8'h10 + i)) begin
            nFail++;
            $display("[TB] FAIL fwft_head idx=%0d got %h want %h", i, RD_data1, 8'(8'h10 + i));
         end
         applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
         nTests++;
         if (RD_data0 !== 8'(8'h10 + i)) begin
            nFail++;
            $display("[TB] FAIL overflow_drain idx=%0d got %h want %h", i, RD_data0, 8'(8'h10 + i));
         end
      end
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      nTests++;
      if ({RD_underflow0, RD_underflow1, LEVEL0, RD_valid0} !== {1'b1, 1'b1, 5'd0, 1'b0}) begin
         nFail++;
         $display("[TB] FAIL underflow_pulse got u=%b%b lvl=%0d v=%b want u=11 lvl=0 v=0", RD_underflow0, RD_underflow1, LEVEL0, RD_valid0);
      end
   endtask

   task automatic test_simultaneous();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 8'(i), 1'b0);
      for (int c = 0; c < 40; c++) begin
         applyStimulus(1'b1, 1'b1, 8'(7 + c), 1'b0);
         nTests++;
         if ({LEVEL0, LEVEL1, RD_data0} !== {5'd7, 5'd7, 8'(c)}) begin
            nFail++;
            $display("[TB] FAIL both_steady cyc=%0d got lvl=%0d/%0d d=%h want 7/7 d=%h", c, LEVEL0, LEVEL1, RD_data0, 8'(c));
         end
      end
      for (int j = 0; j < 9; j++) applyStimulus(1'b1, 1'b0, 8'(47 + j), 1'b0);
      applyStimulus(1'b1, 1'b1, 8'hEE, 1'b0);
      nTests++;
      if ({LEVEL0, WR_overflow0, RD_data0, RD_underflow0} !== {5'd15, 1'b1, 8'd40, 1'b0}) begin
         nFail++;
         $display("[TB] FAIL both_at_full got lvl=%0d o=%b d=%h u=%b want 15 1 28 0", LEVEL0, WR_overflow0, RD_data0, RD_underflow0);
      end
      for (int j = 0; j < 15; j++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      nTests++;
      if (RD_data0 !== 8'd55) begin
         nFail++;
         $display("[TB] FAIL full_drain_last got %h want 37", RD_data0);
      end
      applyStimulus(1'b1, 1'b1, 8'h3C, 1'b0);
      nTests++;
      if ({LEVEL0, RD_underflow0, WR_overflow0, RD_data1} !== {5'd1, 1'b1, 1'b0, 8'h3C}) begin
         nFail++;
         $display("[TB] FAIL both_at_empty got lvl=%0d u=%b o=%b head=%h want 1 1 0 3c", LEVEL0, RD_underflow0, WR_overflow0, RD_data1);
      end
   endtask

   task automatic test_fwft();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      applyStimulus(1'b1, 1'b0, 8'h5A, 1'b0);
      nTests++;
      if ({RD_empty1, RD_data1, RD_valid1} !== {1'b0, 8'h5A, 1'b1}) begin
         nFail++;
         $display("[TB] FAIL fwft_show got e=%b d=%h v=%b want e=0 d=5a v=1", RD_empty1, RD_data1, RD_valid1);
      end
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      nTests++;
      if ({RD_empty1, RD_valid1, LEVEL1} !== {1'b1, 1'b0, 5'd0}) begin
         nFail++;
         $display("[TB] FAIL fwft_pop got e=%b v=%b lvl=%0d want e=1 v=0 lvl=0", RD_empty1, RD_valid1, LEVEL1);
      end
   endtask

   task automatic test_random();
      int wrPct, n;
      logic wr, rd, rst;
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      wrPct = 50;
      for (int c = 0; c < 10000; c++) begin
         if (c % 300 == 0) wrPct = (c / 300) % 3 == 0 ? 80 : ((c / 300) % 3 == 1 ? 20 : 50);
         wr  = ($urandom_range(0, 99) < wrPct);
         rd  = ($urandom_range(0, 99) < (100 - wrPct));
         rst = ($urandom_range(0, 999) == 0);
         applyStimulus(wr, rd, 8'($urandom), rst);
         n = q.size();
         nTests++;
         if ({LEVEL0, WR_full0, RD_empty0, almost_full0, almost_empty0, LEVEL1, WR_full1, RD_empty1, almost_full1, almost_empty1}
             !== {5'(n), n == DEPTH, n == 0, n >= AFL, n <= AEL, 5'(n), n == DEPTH, n == 0, n >= AFL, n <= AEL}) begin
            nFail++;
            $display("[TB] FAIL rand_level cyc=%0d got lvl=%0d/%0d f=%b%b e=%b%b af=%b%b ae=%b%b want lvl=%0d",
                     c, LEVEL0, LEVEL1, WR_full0, WR_full1, RD_empty0, RD_empty1, almost_full0, almost_full1,
                     almost_empty0, almost_empty1, n);
         end
         nTests++;
         if ({WR_overflow0, WR_overflow1, RD_underflow0, RD_underflow1} !== {expOvf, expOvf, expUnf, expUnf}) begin
            nFail++;
            $display("[TB] FAIL rand_pulses cyc=%0d got o=%b%b u=%b%b want o=%b u=%b",
                     c, WR_overflow0, WR_overflow1, RD_underflow0, RD_underflow1, expOvf, expUnf);
         end
         nTests++;
         if ({RD_valid0, RD_data0, RD_valid1} !== {expValid0, expData0, n != 0}) begin
            nFail++;
            $display("[TB] FAIL rand_read0 cyc=%0d got v=%b d=%h v1=%b want v=%b d=%h v1=%b",
                     c, RD_valid0, RD_data0, RD_valid1, expValid0, expData0, n != 0);
         end
         if (n != 0) begin
            nTests++;
            if (RD_data1 !== 8'(q[0])) begin
               nFail++;
               $display("[TB] FAIL rand_head1 cyc=%0d got %h want %h", c, RD_data1, 8'(q[0]));
            end
         end
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      test_reset();
      test_fill_drain();
      test_overflow_underflow();
      test_simultaneous();
      test_fwft();
      test_random();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
